store_unit: RTL and testbench

- Store-side counterpart to the 6502 register load path; it executes STA/STX/STY.
- It takes the selected register value, resolves the effective address for the store's addressing mode, and performs one memory write.
- Indirect modes need pointer reads, so the unit fetches the zero-page pointer bytes itself before writing.
- Sits between the control FSM and the memory bus, next to the A/X/Y registers.

---
 rtl/store_pkg.sv | 32 +++
 rtl/ea_calc.sv | 53 +++++
 rtl/store_unit.sv | 193 +++++++++++++++++++
 tb/tb_store_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store path: addressing-mode codes, FSM states
// and the default zero-page high byte.
package store_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam logic [7:0]  ZP_PAGE_DEF = 8'h00;

  // Addressing-mode encodings carried on the mode input
  localparam logic [2:0] MODE_ZP   = 3'd0;
  localparam logic [2:0] MODE_ZPX  = 3'd1;
  localparam logic [2:0] MODE_ABS  = 3'd2;
  localparam logic [2:0] MODE_ABSX = 3'd3;
  localparam logic [2:0] MODE_IZX  = 3'd4;
  localparam logic [2:0] MODE_IZY  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR_LO,
    ST_PTR_HI,
    ST_CALC,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  // Modes that must fetch a zero-page pointer before the write
  function automatic logic mode_is_indirect(input logic [2:0] m);
    return (m == MODE_IZX) || (m == MODE_IZY);
  endfunction

endpackage

// File: rtl/ea_calc.sv
// Combinational effective-address adder shared by the load and store paths.
// Ports:
//   mode           addressing mode (store_pkg MODE_*)
//   op_lo, op_hi   operand bytes
//   index          X or Y value
//   ptr_lo, ptr_hi pointer bytes fetched from the zero page (indirect modes)
//   ea             resolved effective address
//   ptr            zero-page address of the pointer low byte
module ea_calc
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter logic [7:0]  ZP_PAGE = ZP_PAGE_DEF
) (
  input  logic [2:0]        mode,
  input  logic [7:0]        op_lo,
  input  logic [7:0]        op_hi,
  input  logic [DATA_W-1:0] index,
  input  logic [7:0]        ptr_lo,
  input  logic [7:0]        ptr_hi,
  output logic [ADDR_W-1:0] ea,
  output logic [7:0]        ptr
);

  logic [7:0]  idx8;
  logic [7:0]  zp_sum;
  logic [15:0] abs_base;
  logic [15:0] ind_base;
  logic [15:0] ea16;

  assign idx8 = 8'(index);

  // Zero-page sums wrap inside the page; absolute sums carry into the high byte
  always_comb begin
    zp_sum   = op_lo + idx8;
    abs_base = {op_hi, op_lo};
    ind_base = {ptr_hi, ptr_lo};
    ptr      = (mode == MODE_IZX) ? zp_sum : op_lo;
    ea16     = 16'h0000;
    case (mode)
      MODE_ZP:   ea16 = {ZP_PAGE, op_lo};
      MODE_ZPX:  ea16 = {ZP_PAGE, zp_sum};
      MODE_ABS:  ea16 = abs_base;
      MODE_ABSX: ea16 = abs_base + 16'(idx8);
      MODE_IZX:  ea16 = ind_base;
      MODE_IZY:  ea16 = ind_base + 16'(idx8);
      default:   ea16 = 16'h0000;
    endcase
    ea = ADDR_W'(ea16);
  end

endmodule

// File: rtl/store_unit.sv
// Executes STA/STX/STY: resolves the effective address for the addressing
// mode, fetches zero-page pointer bytes for indirect modes, then issues one
// memory write.
// Ports:
//   FSM_Signal  clock (rising edge)
//   reset_ST    synchronous active-high reset
//   start       begin a store (sampled only when idle)
//   mode        addressing mode, 6/7 illegal
//   src_data    register value to store
//   index       X or Y
//   op_lo/op_hi operand bytes
//   mem_rdata   read data, valid the cycle after mem_re
//   mem_addr, mem_wdata, mem_we, mem_re   registered memory bus
//   busy        high whenever not idle
//   done        one-cycle pulse after the write
//   err         one-cycle pulse on an illegal mode
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter logic [7:0]  ZP_PAGE = ZP_PAGE_DEF
) (
  input  logic              FSM_Signal,
  input  logic              reset_ST,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] src_data,
  input  logic [DATA_W-1:0] index,
  input  logic [7:0]        op_lo,
  input  logic [7:0]        op_hi,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e state, next_state;

  logic [2:0]        mode_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] index_q;
  logic [7:0]        op_lo_q;
  logic [7:0]        op_hi_q;
  logic [7:0]        ptr_lo_q;
  logic [7:0]        ptr_hi_q;

  logic              in_idle;
  logic [2:0]        sel_mode;
  logic [DATA_W-1:0] sel_src;
  logic [DATA_W-1:0] sel_index;
  logic [7:0]        sel_op_lo;
  logic [7:0]        sel_op_hi;
  logic [7:0]        ptr_hi_in;

  logic [ADDR_W-1:0] ea;
  logic [7:0]        ptr;
  logic [7:0]        ptr_inc;

  logic              latch;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_nxt;
  logic              re_nxt;
  logic              done_nxt;
  logic              err_nxt;

  // Outputs are registered, so the first bus cycle is computed from the live
  // inputs while idle; afterwards the latched copies drive the adder.
  assign in_idle   = (state == ST_IDLE);
  assign sel_mode  = in_idle ? mode     : mode_q;
  assign sel_src   = in_idle ? src_data : src_q;
  assign sel_index = in_idle ? index    : index_q;
  assign sel_op_lo = in_idle ? op_lo    : op_lo_q;
  assign sel_op_hi = in_idle ? op_hi    : op_hi_q;

  // In CALC the pointer high byte is still on the bus; use it directly so
  // the write address is ready at the CALC->WRITE edge.
  assign ptr_hi_in = (state == ST_CALC) ? 8'(mem_rdata) : ptr_hi_q;

  // Pointer high byte stays inside the zero page (FF wraps to 00)
  assign ptr_inc = ptr + 8'd1;

  ea_calc #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ZP_PAGE(ZP_PAGE)
  ) u_ea_calc (
    .mode  (sel_mode),
    .op_lo (sel_op_lo),
    .op_hi (sel_op_hi),
    .index (sel_index),
    .ptr_lo(ptr_lo_q),
    .ptr_hi(ptr_hi_in),
    .ea    (ea),
    .ptr   (ptr)
  );

  // Next-state and next-output decode
  always_comb begin
    next_state = state;
    latch      = 1'b0;
    addr_nxt   = mem_addr;
    wdata_nxt  = mem_wdata;
    we_nxt     = 1'b0;
    re_nxt     = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (sel_mode > MODE_IZY) begin
            next_state = ST_ERR;
            err_nxt    = 1'b1;
          end else if (mode_is_indirect(sel_mode)) begin
            next_state = ST_PTR_LO;
            re_nxt     = 1'b1;
            addr_nxt   = ADDR_W'({ZP_PAGE, ptr});
          end else begin
            next_state = ST_WRITE;
            we_nxt     = 1'b1;
            addr_nxt   = ea;
            wdata_nxt  = sel_src;
          end
        end
      end
      ST_PTR_LO: begin
        next_state = ST_PTR_HI;
        re_nxt     = 1'b1;
        addr_nxt   = ADDR_W'({ZP_PAGE, ptr_inc});
      end
      ST_PTR_HI: next_state = ST_CALC;
      ST_CALC: begin
        next_state = ST_WRITE;
        we_nxt     = 1'b1;
        addr_nxt   = ea;
        wdata_nxt  = sel_src;
      end
      ST_WRITE: begin
        next_state = ST_DONE;
        done_nxt   = 1'b1;
      end
      ST_DONE:  next_state = ST_IDLE;
      ST_ERR:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State, operand latches and registered bus outputs
  always_ff @(posedge FSM_Signal) begin
    if (reset_ST) begin
      state     <= ST_IDLE;
      mode_q    <= 3'd0;
      src_q     <= '0;
      index_q   <= '0;
      op_lo_q   <= 8'h00;
      op_hi_q   <= 8'h00;
      ptr_lo_q  <= 8'h00;
      ptr_hi_q  <= 8'h00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
      mem_re    <= re_nxt;
      busy      <= (next_state != ST_IDLE);
      done      <= done_nxt;
      err       <= err_nxt;
      if (latch) begin
        mode_q  <= mode;
        src_q   <= src_data;
        index_q <= index;
        op_lo_q <= op_lo;
        op_hi_q <= op_hi;
      end
      if (state == ST_PTR_HI) ptr_lo_q <= 8'(mem_rdata);
      if (state == ST_CALC)   ptr_hi_q <= 8'(mem_rdata);
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus random stores
// compared against a per-cycle bus expectation derived from the addressing
// rules, with a zero-page memory model answering pointer reads.
module tb_store_unit;

  logic        FSM_Signal = 1'b0;
  logic        reset_ST;
  logic        start;
  logic [2:0]  mode;
  logic [7:0]  src_data;
  logic [7:0]  index;
  logic [7:0]  op_lo;
  logic [7:0]  op_hi;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        busy;
  logic        done;
  logic        err;

  logic [7:0]  zp [256];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_addr = 16'h0000;
  logic [7:0]  exp_wdata = 8'h00;

  store_unit dut (
    .FSM_Signal(FSM_Signal),
    .reset_ST  (reset_ST),
    .start     (start),
    .mode      (mode),
    .src_data  (src_data),
    .index     (index),
    .op_lo     (op_lo),
    .op_hi     (op_hi),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 FSM_Signal = ~FSM_Signal;

  // Zero-page memory: read data appears the cycle after the strobe
  always @(posedge FSM_Signal) begin
    if (mem_re === 1'b1) mem_rdata <= zp[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_cycle(input string tag, input logic we, input logic re,
                             input logic dn, input logic er, input logic bz);
    check({tag, "_we"},    32'(mem_we), 32'(we));
    check({tag, "_re"},    32'(mem_re), 32'(re));
    check({tag, "_done"},  32'(done),   32'(dn));
    check({tag, "_err"},   32'(err),    32'(er));
    check({tag, "_busy"},  32'(busy),   32'(bz));
    check({tag, "_addr"},  32'(mem_addr),  32'(exp_addr));
    check({tag, "_wdata"}, 32'(mem_wdata), 32'(exp_wdata));
    check({tag, "_excl"},  32'(mem_we & mem_re), 32'(0));
  endtask

  // Reference EA from the addressing rules, using integer arithmetic
  function automatic int unsigned ref_ea(input int unsigned m, input int unsigned s_lo,
                                         input int unsigned s_hi, input int unsigned ix);
    int unsigned p;
    int unsigned ptr_word;
    p = (m == 4) ? (s_lo + ix) % 256 : s_lo;
    ptr_word = int'(zp[(p + 1) % 256]) * 256 + int'(zp[p]);
    case (m)
      0: return s_lo;
      1: return (s_lo + ix) % 256;
      2: return s_hi * 256 + s_lo;
      3: return (s_hi * 256 + s_lo + ix) % 65536;
      4: return ptr_word;
      5: return (ptr_word + ix) % 65536;
      default: return 0;
    endcase
  endfunction

  // Call right after a negedge; returns at a negedge with the unit idle.
  task automatic run_store(input string tag, input logic [2:0] m, input logic [7:0] s,
                           input logic [7:0] ix, input logic [7:0] lo, input logic [7:0] hi,
                           input bit hold);
    int unsigned ea;
    int unsigned p;
    int unsigned busy_len;
    bit legal;
    bit indirect;
    logic we, re, dn, er;
    legal    = (m <= 3'd5);
    indirect = (m == 3'd4) || (m == 3'd5);
    p        = (m == 3'd4) ? (int'(lo) + int'(ix)) % 256 : int'(lo);
    ea       = ref_ea(int'(m), int'(lo), int'(hi), int'(ix));
    busy_len = !legal ? 1 : (indirect ? 5 : 2);
    mode = m; src_data = s; index = ix; op_lo = lo; op_hi = hi; start = 1'b1;
    for (int k = 1; k <= int'(busy_len) + 1; k++) begin
      @(negedge FSM_Signal);
      we = 1'b0; re = 1'b0; dn = 1'b0; er = 1'b0;
      if (!legal) begin
        er = (k == 1);
      end else if (!indirect) begin
        if (k == 1) begin we = 1'b1; exp_addr = 16'(ea); exp_wdata = s; end
        dn = (k == 2);
      end else begin
        case (k)
          1: begin re = 1'b1; exp_addr = 16'(p); end
          2: begin re = 1'b1; exp_addr = 16'((p + 1) % 256); end
          4: begin we = 1'b1; exp_addr = 16'(ea); exp_wdata = s; end
          5: dn = 1'b1;
          default: ;
        endcase
      end
      check_cycle($sformatf("%s_c%0d", tag, k), we, re, dn, er, 1'(k <= int'(busy_len)));
      if (hold && k <= int'(busy_len)) begin
        // Starts while busy must be ignored, and the operands stay latched
        start = 1'b1; mode = 3'($urandom); src_data = 8'($urandom); index = 8'($urandom);
        op_lo = 8'($urandom); op_hi = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) zp[i] = 8'($urandom);
    reset_ST = 1'b1; start = 1'b1; mode = 3'd0; src_data = 8'hA5; index = 8'h00;
    op_lo = 8'h42; op_hi = 8'h00;

    // Reset held with start asserted: nothing may move
    repeat (3) begin
      @(negedge FSM_Signal);
      check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    start = 1'b0;
    reset_ST = 1'b0;
    @(negedge FSM_Signal);
    check_cycle("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed cases
    run_store("zp",    3'd0, 8'hA5, 8'h00, 8'h42, 8'h00, 1'b0);
    run_store("zpx",   3'd1, 8'h3C, 8'h20, 8'hF0, 8'h77, 1'b0);
    run_store("absx",  3'd3, 8'h5A, 8'h01, 8'hFF, 8'h12, 1'b0);
    zp[255] = 8'h34;
    zp[0]   = 8'h12;
    run_store("izy",   3'd5, 8'hC3, 8'h10, 8'hFF, 8'h00, 1'b0);
    run_store("ill6",  3'd6, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    run_store("hold",  3'd4, 8'h99, 8'h05, 8'hFA, 8'h00, 1'b1);
    run_store("abs",   3'd2, 8'h81, 8'h00, 8'hCD, 8'hAB, 1'b1);

    // Reset while in PTR_HI: no write afterwards, idle next cycle
    mode = 3'd4; src_data = 8'hEE; index = 8'h03; op_lo = 8'h10; op_hi = 8'h00; start = 1'b1;
    @(negedge FSM_Signal);
    start = 1'b0;
    @(negedge FSM_Signal);
    check("midrst_in_ptr_hi_busy", 32'(busy), 32'(1));
    reset_ST = 1'b1;
    @(negedge FSM_Signal);
    exp_addr = 16'h0000;
    exp_wdata = 8'h00;
    check_cycle("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_ST = 1'b0;
    repeat (5) begin
      @(negedge FSM_Signal);
      check_cycle("midrst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random stores across all modes, including illegal ones
    for (int n = 0; n < 60; n++) begin
      run_store($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
